// File: rtl/oh_arbiter.sv
// ---------------------------------------------------------------------------
// oh_arbiter
//
// Shares one combinational operand handler between two requesters.
// Requester 0 is the execute-stage operand path. Requester 1 is the
// address-generation path.
//
// Arbitration is round-robin. On a tie, the winner is the requester that was
// not accepted last. The winning request drives the handler's RB/I/S inputs.
// The handler's N output is captured into a one-entry result register, which
// is returned with a valid/ready handshake. Each requester also has a
// saturating counter of accepted grants.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqX_valid/rb/imm/sel      request from requester X (X = 0, 1)
//   reqX_ready                 request X accepted this cycle (with valid)
//   oh_rb/oh_i/oh_s            drive to the handler's RB, I and S inputs
//   oh_n                       combinational result from the handler
//   res_valid/n/id/illegal     result register contents
//   res_ready                  consumer takes the result
//   cnt_clr                    synchronous clear of both grant counters
//   gnt_cnt0/gnt_cnt1          saturating accepted-request counts
// ---------------------------------------------------------------------------
module oh_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic [31:0]      req0_rb,
    input  logic [20:0]      req0_imm,
    input  logic [2:0]       req0_sel,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [31:0]      req1_rb,
    input  logic [20:0]      req1_imm,
    input  logic [2:0]       req1_sel,
    output logic             req1_ready,

    output logic [31:0]      oh_rb,
    output logic [20:0]      oh_i,
    output logic [2:0]       oh_s,
    input  logic [31:0]      oh_n,

    output logic             res_valid,
    output logic [31:0]      res_n,
    output logic             res_id,
    output logic             res_illegal,
    input  logic             res_ready,

    input  logic             cnt_clr,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    localparam logic [2:0] SEL_ILLEGAL = 3'b111;

    // Arbitration state: the requester accepted most recently.
    logic        last_gnt_reg;

    logic        res_valid_reg,   res_valid_next;
    logic [31:0] res_n_reg,       res_n_next;
    logic        res_id_reg,      res_id_next;
    logic        res_illegal_reg, res_illegal_next;
    logic        last_gnt_next;

    logic [1:0]  req_valid;
    logic [1:0]  grant;
    logic [1:0]  ready;
    logic        space;
    logic        accept;
    logic        accept_id;

    assign req_valid = {req1_valid, req0_valid};

    // The slot can take a new result when it is empty or is being drained
    // this cycle. Drain and accept in the same cycle replace the old result.
    assign space = ~res_valid_reg | res_ready;

    // The grant does not depend on space. A stalled requester keeps its grant,
    // and its operands stay on the handler, because last_gnt moves only on
    // accept.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_gnt_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign ready      = grant & {2{space}};
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign accept     = |ready;
    assign accept_id  = ready[1];

    // Handler drive. The idle pattern uses the illegal select, so the handler
    // output is a known zero when nobody is granted.
    always_comb begin
        oh_rb = 32'd0;
        oh_i  = 21'd0;
        oh_s  = SEL_ILLEGAL;
        if (grant[0]) begin
            oh_rb = req0_rb;
            oh_i  = req0_imm;
            oh_s  = req0_sel;
        end else if (grant[1]) begin
            oh_rb = req1_rb;
            oh_i  = req1_imm;
            oh_s  = req1_sel;
        end
    end

    // Result slot next state. The payload changes only on accept. A drain
    // clears only the valid flag.
    always_comb begin
        res_valid_next   = res_valid_reg;
        res_n_next       = res_n_reg;
        res_id_next      = res_id_reg;
        res_illegal_next = res_illegal_reg;
        last_gnt_next    = last_gnt_reg;
        if (accept) begin
            res_valid_next   = 1'b1;
            res_n_next       = oh_n;
            res_id_next      = accept_id;
            res_illegal_next = (oh_s == SEL_ILLEGAL);
            last_gnt_next    = accept_id;
        end else if (res_valid_reg && res_ready) begin
            res_valid_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg   <= 1'b0;
            res_n_reg       <= 32'd0;
            res_id_reg      <= 1'b0;
            res_illegal_reg <= 1'b0;
            // Reset to 1 so that requester 0 wins the first tie.
            last_gnt_reg    <= 1'b1;
        end else begin
            res_valid_reg   <= res_valid_next;
            res_n_reg       <= res_n_next;
            res_id_reg      <= res_id_next;
            res_illegal_reg <= res_illegal_next;
            last_gnt_reg    <= last_gnt_next;
        end
    end

    assign res_valid   = res_valid_reg;
    assign res_n       = res_n_reg;
    assign res_id      = res_id_reg;
    assign res_illegal = res_illegal_reg;

    // Per-requester saturating grant counters. A clear wins over an
    // increment in the same cycle.
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_reg, cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_clr) begin
                    cnt_next = '0;
                end else if (ready[gi] && !(&cnt_reg)) begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            if (gi == 0) begin : gen_out0
                assign gnt_cnt0 = cnt_reg;
            end else begin : gen_out1
                assign gnt_cnt1 = cnt_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_oh_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oh_arbiter
//
// Directed testbench for oh_arbiter, built with CNT_W = 2 so that counter
// saturation is reachable.
//
// The operand handler is stood in for by a small combinational model. It
// covers only the select codes used here:
//   000 passes RB
//   011 places I at bit 11
//   100 shifts RB right by (31 - I[9:5])
//   111 (illegal) returns 0
//
// Inputs change on the falling edge. Readies and the handler drive are
// checked 1 ns later. Registered outputs are checked 1 ns after the rising
// edge.
// ---------------------------------------------------------------------------
module tb_oh_arbiter;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0]      req0_rb = '0, req1_rb = '0;
    logic [20:0]      req0_imm = '0, req1_imm = '0;
    logic [2:0]       req0_sel = '0, req1_sel = '0;
    logic             req0_ready, req1_ready;
    logic [31:0]      oh_rb;
    logic [20:0]      oh_i;
    logic [2:0]       oh_s;
    logic [31:0]      oh_n;
    logic             res_valid, res_id, res_illegal;
    logic [31:0]      res_n;
    logic             res_ready = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    oh_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rb(req0_rb), .req0_imm(req0_imm),
        .req0_sel(req0_sel), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rb(req1_rb), .req1_imm(req1_imm),
        .req1_sel(req1_sel), .req1_ready(req1_ready),
        .oh_rb(oh_rb), .oh_i(oh_i), .oh_s(oh_s), .oh_n(oh_n),
        .res_valid(res_valid), .res_n(res_n), .res_id(res_id),
        .res_illegal(res_illegal), .res_ready(res_ready),
        .cnt_clr(cnt_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    // Stand-in operand handler
    always_comb begin
        case (oh_s)
            3'b000:  oh_n = oh_rb;
            3'b011:  oh_n = {oh_i, 11'd0};
            3'b100:  oh_n = oh_rb >> (5'd31 - oh_i[9:5]);
            3'b111:  oh_n = 32'd0;
            default: oh_n = oh_rb ^ {11'd0, oh_i};
        endcase
    end

    task automatic rise();
        @(posedge clk); #1;
    endtask

    task automatic fall();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%0b want=0", res_valid); end
        total++; if (res_n !== 32'd0) begin bad++; $display("FAIL reset_res_n got=%h want=0", res_n); end
        total++; if (res_id !== 1'b0 || res_illegal !== 1'b0) begin bad++; $display("FAIL reset_id_ill got=%0b%0b want=00", res_id, res_illegal); end
        total++; if (gnt_cnt0 !== 2'd0 || gnt_cnt1 !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d,%0d want=0,0", gnt_cnt0, gnt_cnt1); end
        total++; if (oh_s !== 3'b111 || oh_rb !== 32'd0 || req0_ready !== 1'b0) begin bad++; $display("FAIL reset_idle_drive got s=%b rb=%h rdy0=%0b want s=111 rb=0 rdy0=0", oh_s, oh_rb, req0_ready); end
        $display("reset: res_valid=%0b res_n=%h cnt=%0d,%0d", res_valid, res_n, gnt_cnt0, gnt_cnt1);
    endtask

    task automatic test_single_lsr();
        @(negedge clk);
        req0_valid = 1'b1; req0_sel = 3'b100; req0_rb = 32'h8000_0000;
        req0_imm = 21'(30 << 5); res_ready = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL lsr_ready got=%0b%0b want=01", req1_ready, req0_ready); end
        total++; if (oh_rb !== 32'h8000_0000 || oh_s !== 3'b100 || oh_i !== 21'h3c0) begin bad++; $display("FAIL lsr_drive got rb=%h i=%h s=%b", oh_rb, oh_i, oh_s); end
        rise();
        req0_valid = 1'b0;
        total++; if (res_valid !== 1'b1 || res_n !== 32'h4000_0000 || res_id !== 1'b0) begin bad++; $display("FAIL lsr_result got v=%0b n=%h id=%0b want v=1 n=40000000 id=0", res_valid, res_n, res_id); end
        total++; if (gnt_cnt0 !== 2'd1) begin bad++; $display("FAIL lsr_cnt0 got=%0d want=1", gnt_cnt0); end
        $display("single lsr: res_n=%h id=%0b cnt0=%0d", res_n, res_id, gnt_cnt0);
        rise();
        total++; if (res_valid !== 1'b0 || res_n !== 32'h4000_0000) begin bad++; $display("FAIL lsr_drain got v=%0b n=%h want v=0 n=40000000", res_valid, res_n); end
    endtask

    task automatic test_tie();
        logic [31:0] exp_n;
        logic        exp_id;
        do_reset();
        req0_valid = 1'b1; req0_sel = 3'b000; req0_rb = 32'h11; req0_imm = '0;
        req1_valid = 1'b1; req1_sel = 3'b011; req1_rb = '0;     req1_imm = 21'h1;
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_id = 1'(k % 2);
            exp_n  = exp_id ? 32'h0000_0800 : 32'h0000_0011;
            #1;
            total++; if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin bad++; $display("FAIL tie_ready[%0d] got=%b%b want id%0b", k, req1_ready, req0_ready, exp_id); end
            rise();
            total++; if (res_valid !== 1'b1 || res_id !== exp_id || res_n !== exp_n) begin bad++; $display("FAIL tie_result[%0d] got v=%0b id=%0b n=%h want v=1 id=%0b n=%h", k, res_valid, res_id, res_n, exp_id, exp_n); end
            $display("tie accept %0d: id=%0b res_n=%h", k, res_id, res_n);
            @(negedge clk);
        end
        total++; if (gnt_cnt0 !== 2'd3 || gnt_cnt1 !== 2'd3) begin bad++; $display("FAIL tie_cnt got=%0d,%0d want=3,3", gnt_cnt0, gnt_cnt1); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rise();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req0_valid = 1'b1; req0_sel = 3'b000; req0_rb = 32'h0000_aaaa; res_ready = 1'b1;
        rise();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_sel = 3'b000; req1_rb = 32'h0000_5555; req1_imm = '0;
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fall();
            total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b%b want=00", k, req1_ready, req0_ready); end
            total++; if (oh_rb !== 32'h0000_5555) begin bad++; $display("FAIL bp_drive[%0d] got=%h want=00005555", k, oh_rb); end
            rise();
            total++; if (res_valid !== 1'b1 || res_n !== 32'h0000_aaaa || res_id !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d] got v=%0b n=%h id=%0b want v=1 n=0000aaaa id=0", k, res_valid, res_n, res_id); end
            $display("backpressure cycle %0d: res_n=%h held", k, res_n);
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b want=1", req1_ready); end
        rise();
        req1_valid = 1'b0;
        total++; if (res_valid !== 1'b1 || res_n !== 32'h0000_5555 || res_id !== 1'b1) begin bad++; $display("FAIL bp_replace got v=%0b n=%h id=%0b want v=1 n=00005555 id=1", res_valid, res_n, res_id); end
        $display("backpressure release: res_n=%h id=%0b", res_n, res_id);
        rise();
    endtask

    task automatic test_illegal();
        @(negedge clk);
        cnt_clr = 1'b1;
        rise();
        cnt_clr = 1'b0;
        total++; if (gnt_cnt0 !== 2'd0 || gnt_cnt1 !== 2'd0) begin bad++; $display("FAIL clr_idle got=%0d,%0d want=0,0", gnt_cnt0, gnt_cnt1); end
        @(negedge clk);
        req1_valid = 1'b1; req1_sel = 3'b111; req1_rb = 32'h1234_5678; res_ready = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b1 || oh_s !== 3'b111) begin bad++; $display("FAIL ill_accept got rdy=%0b s=%b want rdy=1 s=111", req1_ready, oh_s); end
        rise();
        req1_valid = 1'b0;
        total++; if (res_valid !== 1'b1 || res_illegal !== 1'b1 || res_n !== 32'd0 || res_id !== 1'b1) begin bad++; $display("FAIL ill_result got v=%0b ill=%0b n=%h id=%0b want 1 1 0 1", res_valid, res_illegal, res_n, res_id); end
        total++; if (gnt_cnt1 !== 2'd1) begin bad++; $display("FAIL ill_cnt1 got=%0d want=1", gnt_cnt1); end
        $display("illegal: res_illegal=%0b res_n=%h cnt1=%0d", res_illegal, res_n, gnt_cnt1);
        rise();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        @(negedge clk);
        req0_valid = 1'b1; req0_sel = 3'b000; req0_rb = 32'h0000_0042; res_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            exp_cnt = (k > 3) ? 2'd3 : 2'(k);
            rise();
            total++; if (gnt_cnt0 !== exp_cnt) begin bad++; $display("FAIL sat_cnt0[%0d] got=%0d want=%0d", k, gnt_cnt0, exp_cnt); end
            $display("saturation accept %0d: cnt0=%0d", k, gnt_cnt0);
        end
        total++; if (res_illegal !== 1'b0 || res_n !== 32'h42) begin bad++; $display("FAIL sat_result got ill=%0b n=%h want ill=0 n=42", res_illegal, res_n); end
        @(negedge clk);
        cnt_clr = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL sat_clr_ready got=%0b want=1", req0_ready); end
        rise();
        cnt_clr = 1'b0; req0_valid = 1'b0;
        total++; if (gnt_cnt0 !== 2'd0) begin bad++; $display("FAIL sat_clr_cnt0 got=%0d want=0", gnt_cnt0); end
        $display("saturation clear: cnt0=%0d", gnt_cnt0);
        rise();
    endtask

    task automatic test_reset_hold();
        @(negedge clk);
        req0_valid = 1'b1; req0_sel = 3'b000; req0_rb = 32'h0000_0077; res_ready = 1'b0;
        rise();
        total++; if (res_valid !== 1'b1 || res_n !== 32'h77 || req0_ready !== 1'b0) begin bad++; $display("FAIL rh_setup got v=%0b n=%h rdy0=%0b want v=1 n=77 rdy0=0", res_valid, res_n, req0_ready); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (res_valid !== 1'b0 || res_n !== 32'd0) begin bad++; $display("FAIL rh_async got v=%0b n=%h want v=0 n=0", res_valid, res_n); end
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL rh_ready got=%0b want=1", req0_ready); end
        $display("reset while holding: res_valid=%0b res_n=%h", res_valid, res_n);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req1_valid = 1'b1; req1_sel = 3'b011; req1_imm = 21'h1; res_ready = 1'b1;
        #1;
        total++; if ({req1_ready, req0_ready} !== 2'b01) begin bad++; $display("FAIL rh_tie_ready got=%b%b want=01", req1_ready, req0_ready); end
        rise();
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++; if (res_valid !== 1'b1 || res_id !== 1'b0 || res_n !== 32'h77) begin bad++; $display("FAIL rh_tie_result got v=%0b id=%0b n=%h want v=1 id=0 n=77", res_valid, res_id, res_n); end
        $display("post-reset tie: id=%0b res_n=%h", res_id, res_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_lsr();
        test_tie();
        test_backpressure();
        test_illegal();
        test_saturation();
        test_reset_hold();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oh_arbiter.md
# oh_arbiter

Shares the single combinational operand handler between two requesters: requester 0 is the execute-stage operand path, requester 1 is the address-generation path. The block arbitrates round-robin and drives the handler's RB, I and S inputs from the winning requester. It captures the handler's N output into a one-entry result register and returns it with a valid/ready handshake. It also counts grants per requester for performance monitoring.

## Interface
- CNT_W, 16, width of each saturating grant counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req0_valid / req1_valid  in  1  request present
- req0_rb / req1_rb  in  32  register operand
- req0_imm / req1_imm  in  21  immediate field
- req0_sel / req1_sel  in  3  handler select code
- req0_ready / req1_ready  out  1  request accepted this cycle when high with valid
- oh_rb  out  32  to handler RB
- oh_i  out  21  to handler I
- oh_s  out  3  to handler S
- oh_n  in  32  from handler N (combinational)
- res_valid  out  1  result register occupied
- res_n  out  32  captured operand
- res_id  out  1  requester that produced res_n
- res_illegal  out  1  request used sel 3'b111
- res_ready  in  1  consumer takes result
- cnt_clr  in  1  synchronous clear of both counters
- gnt_cnt0 / gnt_cnt1  out  CNT_W  accepted-request counts, saturating

## Operation
- Slot free: space = ~res_valid | res_ready.
- Grant, combinational:
  - Only one reqX_valid: grant X.
  - Both valid: grant the requester not equal to last_gnt.
  - Neither valid: no grant.
- reqX_ready = grant_X & space. At most one ready per cycle. Ready may depend combinationally on valid.
- Handler drive:
  - On a grant: oh_rb/oh_i/oh_s = granted reqX_rb/imm/sel, even when space=0.
  - With no grant: oh_rb=0, oh_i=0, oh_s=3'b111.
- Accept (valid&ready on X), at the next edge:
  - res_n <= oh_n
  - res_id <= X
  - res_illegal <= (sel==3'b111)
  - res_valid <= 1
  - last_gnt <= X
  - gnt_cntX increments unless it is all ones.
- Illegal sel: the request is still accepted, and res_n holds whatever the handler returns (0).
- Drain: res_valid & res_ready with no accept in the same cycle -> res_valid <= 0. res_n, res_id and res_illegal keep their old values.
- Drain and accept in the same cycle: the new result replaces the old one, and res_valid stays 1.
- res_valid & ~res_ready: res_n, res_id and res_illegal are held stable, and both readies are 0.
- last_gnt changes only on accept. If a requester is granted but stalled, the grant stays with it while it keeps valid high.
- cnt_clr: both counters go to 0 at the next edge, and this takes priority over an increment in the same cycle.

## Timing
- Reset values: res_valid=0, res_n=0, res_id=0, res_illegal=0, gnt_cnt0=gnt_cnt1=0, last_gnt=1 (requester 0 wins the first tie).
- Reset assertion clears all state immediately, including a held unconsumed result. Readies follow the cleared state combinationally.
- Latency is one cycle: accepted at edge T, result visible with res_valid=1 after edge T.
- Throughput is one result per cycle while res_ready is held high.
- No combinational path from oh_n to any output except through the result register.
- Worst-case wait for a valid requester is one accepted transfer of the other requester.

## Test plan
- **Single request, logical shift right:** req0 with sel=3'b100, rb=32'h80000000, imm[9:5]=5'd30.
  - Required: res_valid=1 one cycle later, res_n=32'h40000000, res_id=0, gnt_cnt0=1.
- **Tie after reset:** req0 and req1 both valid with res_ready=1. req0 uses sel=000, rb=32'h11; req1 uses sel=011, imm=21'h1.
  - Required: results in order 32'h11 (id0) then 32'h00000800 (id1).
  - Then hold both valid for 4 more accepts. Required: ids alternate 0,1,0,1.
- **Backpressure:** hold res_ready=0 for 3 cycles after a result.
  - Required: req readies are 0, and res_n is unchanged.
  - Then raise res_ready with a pending req1. Required: res_n is replaced in the same cycle, with no bubble.
- **Illegal select:** req1 with sel=3'b111.
  - Required: res_illegal=1, res_n=0, gnt_cnt1 increments.
- **Counter saturation:** with CNT_W=2, make 5 req0 accepts.
  - Required: gnt_cnt0 reads 3.
  - Then assert cnt_clr during a 6th accept. Required: gnt_cnt0 reads 0.
- **Reset while holding:** assert rst_n=0 while res_valid=1 and res_ready=0.
  - Required: res_valid=0 and res_n=0 immediately.
  - After release, the first tie goes to req0.
